// File: rtl/jtvigil_pal_pkg.sv
// jtvigil_pal_pkg
// Shared constants for the Vigilante palette RAM scheduler: the slot numbers
// of the per-pixel time-slot schedule, the colour-select codes placed in the
// top two palette address bits, and the packed 5-bit RGB triple.
package jtvigil_pal_pkg;

  localparam logic [2:0] SLOT_R    = 3'd0;  // R address out
  localparam logic [2:0] SLOT_G    = 3'd1;  // G address out, R data back
  localparam logic [2:0] SLOT_B    = 3'd2;  // B address out, G data back
  localparam logic [2:0] SLOT_BCAP = 3'd3;  // B data back
  localparam logic [2:0] SLOT_CPU  = 3'd4;  // CPU access issued
  localparam logic [2:0] SLOT_OK   = 3'd5;  // CPU completion / read data back
  localparam logic [2:0] SLOT_LAST = 3'd7;  // counter saturates here

  localparam logic [1:0] CSEL_R = 2'd0;
  localparam logic [1:0] CSEL_G = 2'd1;
  localparam logic [1:0] CSEL_B = 2'd2;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb5_t;

endpackage

// File: rtl/jtvigil_pal_cpureq.sv
// jtvigil_pal_cpureq
// CPU side of the palette scheduler. Detects the rising edge of cpu_cs_i,
// latches the request (address, data, direction) into a pending slot,
// issues it when the scheduler grants a CPU slot, and produces the one-cycle
// cpu_ok_o pulse plus the read data the cycle after the access.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   cpu_cs_i/rnw_i/addr_i/dout_i   raw CPU request
//   slot_en_i           scheduler says this cycle may carry a CPU access
//   ram_dout_i          registered RAM read data
//   issue_o             a latched request drives the RAM this cycle
//   req_rnw_o/addr_o/data_o        the latched request
//   cpu_din_o, cpu_ok_o read data and completion pulse to the CPU
module jtvigil_pal_cpureq #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cs_i,
  input  logic          cpu_rnw_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_dout_i,
  input  logic          slot_en_i,
  input  logic [7:0]    ram_dout_i,
  output logic          issue_o,
  output logic          req_rnw_o,
  output logic [AW-1:0] req_addr_o,
  output logic [7:0]    req_data_o,
  output logic [7:0]    cpu_din_o,
  output logic          cpu_ok_o
);

  logic          cs_q;
  logic          pend_q;
  logic          rnw_q;
  logic          ok_q;
  logic          rd_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic [7:0]    din_q;
  logic          rise;
  logic          latch;

  assign rise  = cpu_cs_i & ~cs_q;
  assign latch = rise & ~pend_q;
  // pending stays set through the ok cycle; masking with ok_q stops a
  // back-to-back CPU slot from re-issuing the same access
  assign issue_o = pend_q & ~ok_q & slot_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b0;
      pend_q <= 1'b0;
      rnw_q  <= 1'b1;
      ok_q   <= 1'b0;
      rd_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      cs_q <= cpu_cs_i;
      if (ok_q) begin
        pend_q <= 1'b0;
      end else if (latch) begin
        pend_q <= 1'b1;
        rnw_q  <= cpu_rnw_i;
      end
      ok_q <= issue_o;
      rd_q <= issue_o & rnw_q;
      if (rd_q) din_q <= ram_dout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q <= cpu_addr_i;
      data_q <= cpu_dout_i;
    end
  end

  assign req_rnw_o  = rnw_q;
  assign req_addr_o = addr_q;
  assign req_data_o = data_q;
  assign cpu_ok_o   = ok_q;
  // read data is presented straight from the RAM on the ok cycle and held
  // from the register afterwards
  assign cpu_din_o  = rd_q ? ram_dout_i : din_q;

endmodule

// File: rtl/jtvigil_pal_sched.sv
// jtvigil_pal_sched
// Time-slot scheduler sharing the single-port palette RAM between the video
// fetch (R, G, B bytes per pixel) and the main CPU. A 3-bit slot counter
// restarts after every pxl_cen: slots 0-2 present the R/G/B addresses,
// slots 1-3 capture the returned bytes, slot 4 carries a pending CPU access
// and slot 5 completes it. Colour is blanked and registered on pxl_cen.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   pxl_cen, LHBL, LVBL      pixel enable and active-low blanks
//   vid_addr                 palette index, sampled on pxl_cen
//   cpu_cs/rnw/addr/dout     CPU request, cpu_din/cpu_ok its response
//   ram_addr/din/we, ram_dout  palette RAM (1-cycle registered read)
//   red, green, blue         5-bit pixel colour
//
// Build option: JTVIGIL_PAL_GRAY_EN replaces the video fetch with a grey
// ramp from vidx[3:0] and makes every slot a CPU slot.
module jtvigil_pal_sched #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-3:0] vid_addr,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_ok,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic [4:0]    red,
  output logic [4:0]    green,
  output logic [4:0]    blue
);
  import jtvigil_pal_pkg::*;

  logic [2:0]    slot_q, slot_d;
  logic [AW-3:0] vidx_q;
  rgb5_t         rgb_q;
  logic          blank;
  logic          cpu_slot;
  logic          issue;
  logic          req_rnw;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_data;

  assign blank = ~LVBL | ~LHBL;

  always_comb begin
    slot_d = slot_q;
    if (pxl_cen) slot_d = 3'd0;
    else if (slot_q != SLOT_LAST) slot_d = slot_q + 3'd1;
  end

  // Counter idles saturated at 7 out of reset so nothing is fetched or
  // issued until the first pxl_cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_LAST;
      vidx_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (pxl_cen) vidx_q <= vid_addr;
    end
  end

  jtvigil_pal_cpureq #(.AW(AW)) u_cpureq (
    .clk        (clk),
    .rst        (rst),
    .cpu_cs_i   (cpu_cs),
    .cpu_rnw_i  (cpu_rnw),
    .cpu_addr_i (cpu_addr),
    .cpu_dout_i (cpu_dout),
    .slot_en_i  (cpu_slot),
    .ram_dout_i (ram_dout),
    .issue_o    (issue),
    .req_rnw_o  (req_rnw),
    .req_addr_o (req_addr),
    .req_data_o (req_data),
    .cpu_din_o  (cpu_din),
    .cpu_ok_o   (cpu_ok)
  );

  assign ram_we  = issue & ~req_rnw;
  assign ram_din = ram_we ? req_data : '0;

`ifdef JTVIGIL_PAL_GRAY_EN
  logic [4:0] gray;

  assign cpu_slot = 1'b1;
  assign gray     = {vidx_q[3:0], 1'b0};

  always_comb begin
    ram_addr = '0;
    if (issue) ram_addr = req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (pxl_cen) begin
      rgb_q <= blank ? '0 : {gray, gray, gray};
    end
  end
`else
  rgb5_t pix_q;

  assign cpu_slot = (slot_q == SLOT_CPU);

  always_comb begin
    ram_addr = '0;
    case (slot_q)
      SLOT_R:   ram_addr = {CSEL_R, vidx_q};
      SLOT_G:   ram_addr = {CSEL_G, vidx_q};
      SLOT_B:   ram_addr = {CSEL_B, vidx_q};
      default:  if (issue) ram_addr = req_addr;
    endcase
  end

  // RAM data lags the address by one slot, so each byte is captured one
  // slot after its address was presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      rgb_q <= '0;
    end else begin
      case (slot_q)
        SLOT_G:    pix_q.r <= ram_dout[4:0];
        SLOT_B:    pix_q.g <= ram_dout[4:0];
        SLOT_BCAP: pix_q.b <= ram_dout[4:0];
        default:   ;
      endcase
      if (pxl_cen) rgb_q <= blank ? '0 : pix_q;
    end
  end
`endif

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_jtvigil_pal_sched.sv
module tb_jtvigil_pal_sched;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          pxl_cen, LHBL, LVBL;
  logic [AW-3:0] vid_addr;
  logic          cpu_cs, cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout, cpu_din;
  logic          cpu_ok;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;
  logic          ram_we;
  logic [4:0]    red, green, blue;

  always #5 clk = ~clk;

  jtvigil_pal_sched #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .vid_addr(vid_addr), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ok(cpu_ok), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .red(red), .green(green),
    .blue(blue)
  );

  typedef struct {
    logic        rnw;
    logic [10:0] addr;
    logic [7:0]  data;
    int          cyc;
    int          slot;
  } req_t;

  req_t        cq[$];
  logic [14:0] vq[$];
  logic [7:0]  shadow [2048];
  logic [7:0]  mem    [2048];
  logic        load;
  logic [8:0]  vtab [8] = '{9'h123, 9'h123, 9'h123, 9'h0A5,
                            9'h1FF, 9'h000, 9'h07E, 9'h123};
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          bslot = 7;
  int          ok_seen = 0;
  logic        front_we = 1'b0;
  logic [8:0]  vcur = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // palette RAM: registered read, write on ram_we
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= shadow[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  // pixel enable every 8 clocks; new index and blanks each pixel
  initial begin : gen
    int ph;
    int pix;
    ph = 0; pix = 0;
    pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; vid_addr = 9'h123;
    forever begin
      @(negedge clk);
      pxl_cen = (ph == 7);
      if (ph == 0) begin
        vid_addr = vtab[pix % 8];
        LHBL = !(pix % 8 == 5);
        LVBL = !(pix % 8 == 6);
        pix++;
      end
      ph = (ph + 1) % 8;
    end
  end

  // monitor: slot model, video scoreboard, CPU scoreboard
  initial begin : mon
    logic        cen_s, rst_s;
    logic [8:0]  vid_s;
    logic [14:0] e;
    req_t        it;
    int          exp_lat;
    forever begin
      @(posedge clk);
      cen_s = pxl_cen; rst_s = rst; vid_s = vid_addr;
      cyc++;
      if (rst_s) bslot = 7;
      else if (cen_s) bslot = 0;
      else if (bslot < 7) bslot++;
      #1;
      if (rst_s) begin
        cq.delete();
        vq.delete();
        vq.push_back('0);
        vcur = '0;
        front_we = 1'b0;
      end else begin
        if (cen_s) begin
          if (vq.size() > 0) begin
            e = vq.pop_front();
            if (!LVBL || !LHBL) e = '0;
            chk("red",   32'(red),   32'(e[14:10]));
            chk("green", 32'(green), 32'(e[9:5]));
            chk("blue",  32'(blue),  32'(e[4:0]));
          end
          vq.push_back({shadow[{2'd0, vid_s}][4:0], shadow[{2'd1, vid_s}][4:0],
                        shadow[{2'd2, vid_s}][4:0]});
          vcur = vid_s;
        end
        if (bslot < 3) chk("vaddr", 32'(ram_addr), 32'({2'(bslot), vcur}));
        if (ram_we) begin
          chk("we_slot", 32'(bslot), 32'd4);
          if (cq.size() == 0) begin
            chk("we_unexp", 32'(ram_we), 32'd0);
          end else begin
            chk("we_addr", 32'(ram_addr), 32'(cq[0].addr));
            chk("we_din",  32'(ram_din),  32'(cq[0].data));
            chk("we_rnw",  32'(cq[0].rnw), 32'd0);
            chk("we_dup",  32'(front_we), 32'd0);
            front_we = 1'b1;
          end
        end
        if (cpu_ok) begin
          if (cq.size() == 0) begin
            chk("ok_unexp", 32'(cpu_ok), 32'd0);
          end else begin
            it = cq.pop_front();
            exp_lat = (it.slot < 4) ? 5 - it.slot : 13 - it.slot;
            chk("ok_slot", 32'(bslot), 32'd5);
            chk("ok_lat", 32'(cyc - it.cyc), 32'(exp_lat));
            if (it.rnw) chk("rd_data", 32'(cpu_din), 32'(it.data));
            else        chk("wr_done", 32'(front_we), 32'd1);
            front_we = 1'b0;
          end
          ok_seen++;
        end
      end
    end
  end

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bslot != s && n < 32);
    chk("slot_wait", 32'(bslot), 32'(s));
  endtask

  task automatic cpu_access(input logic rnw, input logic [10:0] a,
                            input logic [7:0] d, input int s, input int hold);
    int   st;
    int   n;
    req_t it;
    wait_slot(s);
    st = ok_seen;
    cpu_cs = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d;
    it.rnw = rnw; it.addr = a; it.data = rnw ? shadow[a] : d;
    it.cyc = cyc; it.slot = bslot;
    cq.push_back(it);
    if (!rnw) shadow[a] = d;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      cpu_cs = 1'b0;
    end
    n = 0;
    while (ok_seen == st && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ok_seen", 32'(ok_seen != st), 32'd1);
    cpu_cs = 1'b0;
  endtask

  initial begin : main
    int   start;
    req_t it;
    rst = 1'b1; load = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
    for (int i = 0; i < 2048; i++) shadow[i] = 8'($urandom);
    shadow[11'h123] = 8'h11;
    shadow[11'h323] = 8'h0A;
    shadow[11'h523] = 8'h1F;
    repeat (3) @(negedge clk);
    load = 1'b0;
    chk("rst_red",   32'(red),      32'd0);
    chk("rst_green", 32'(green),    32'd0);
    chk("rst_blue",  32'(blue),     32'd0);
    chk("rst_ok",    32'(cpu_ok),   32'd0);
    chk("rst_din",   32'(cpu_din),  32'd0);
    chk("rst_addr",  32'(ram_addr), 32'd0);
    chk("rst_wdat",  32'(ram_din),  32'd0);
    chk("rst_we",    32'(ram_we),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);

    cpu_access(1'b0, 11'h345, 8'h5A, 6, 0);
    cpu_access(1'b1, 11'h345, 8'h00, 6, 0);
    cpu_access(1'b0, 11'h0C0, 8'h7A, 3, 0);
    cpu_access(1'b1, 11'h523, 8'h00, 2, 0);

    start = ok_seen;
    cpu_access(1'b0, 11'h346, 8'h21, 6, 2);
    repeat (20) @(negedge clk);
    chk("ok_once", 32'(ok_seen - start), 32'd1);

    // reset while a write is on the RAM port
    wait_slot(1);
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 11'h7F0; cpu_dout = 8'h33;
    it.rnw = 1'b0; it.addr = 11'h7F0; it.data = 8'h33;
    it.cyc = cyc; it.slot = bslot;
    cq.push_back(it);
    wait_slot(4);
    chk("we_pre_rst", 32'(ram_we), 32'd1);
    rst = 1'b1; cpu_cs = 1'b0;
    #1;
    chk("we_rst", 32'(ram_we), 32'd0);
    chk("ok_rst", 32'(cpu_ok), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = ok_seen;
    repeat (48) @(negedge clk);
    chk("no_ok_after_rst", 32'(ok_seen - start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
